byte_mem_responder: RTL and testbench

- Memory-side responder for the processor's multicycle FSM.
- Accepts one load/store request at a time, checks alignment and range, and accesses four byte-lane synchronous RAM banks.
- Returns a single-cycle response with read data or an error flag.
- Sits between the core's memory-access states and on-chip block RAM; supplies the done/error indications the core's WAIT states consume.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_byte_bank.sv | 26 ++
 rtl/byte_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_byte_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, FSM states and lane helpers for byte_mem_responder
package mem_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Banks touched by an access of the given size at the given byte offset.
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [LANES-1:0] mask;
        mask = '0;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << off;
            SIZE_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_byte_bank.sv
// rtl/mem_byte_bank.sv - 8-bit single-port synchronous RAM bank with enable and write enable
module mem_byte_bank #(
    parameter int ROW_BITS = 10
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [ROW_BITS-1:0] row,
    input  logic [7:0]          din,
    output logic [7:0]          dout
);

    logic [7:0] mem [2**ROW_BITS];

    // dout keeps the last read while the bank is idle; the top relies on that across WAIT.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[row] <= din;
            end else begin
                dout <= mem[row];
            end
        end
    end

endmodule

// File: rtl/byte_mem_responder.sv
// rtl/byte_mem_responder.sv - single-request load/store responder over four byte-lane RAM banks
// Optional wait states: define MEM_WAIT_STATES_EN to insert WAIT_CYCLES stall cycles per request.
module byte_mem_responder
    import mem_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic [31:0]          req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_error
);

    localparam int ROW_BITS = ADDR_WIDTH - 2;

    state_t state, state_next;

    logic                 accept;
    logic                 req_error;
    logic                 bank_en;
    logic                 write_q;
    logic [1:0]           size_q;
    logic [1:0]           off_q;
    logic [ROW_BITS-1:0]  row_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 err_q;
    logic [LANES-1:0]     mask_q;
    logic [WORD_SIZE-1:0] hold_rdata;
    logic                 hold_error;
    logic [WORD_SIZE-1:0] rdata_live;
    logic [7:0]           bank_din  [LANES];
    logic [7:0]           bank_dout [LANES];

    assign accept = req_valid & req_ready;

    always_comb begin
        req_error = 1'b0;
        if (req_size == 2'b00)                              req_error = 1'b1;
        if (req_size == SIZE_HALF && req_addr[0])           req_error = 1'b1;
        if (req_size == SIZE_WORD && (|req_addr[1:0]))      req_error = 1'b1;
        if (|req_addr[31:ADDR_WIDTH])                       req_error = 1'b1;
    end

`ifdef MEM_WAIT_STATES_EN
    localparam bit USE_WAIT = (WAIT_CYCLES > 0);
    localparam int CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == ACCESS) begin
            wait_cnt <= CW'(WAIT_CYCLES - 1);
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        bank_en    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ACCESS;
            end
            ACCESS: begin
                bank_en = ~err_q;
`ifdef MEM_WAIT_STATES_EN
                state_next = USE_WAIT ? WAIT : RESP;
`else
                state_next = RESP;
`endif
            end
            WAIT: begin
`ifdef MEM_WAIT_STATES_EN
                if (wait_cnt == '0) state_next = RESP;
`else
                state_next = IDLE;
`endif
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            row_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            mask_q  <= '0;
        end else if (accept) begin
            write_q <= req_write;
            size_q  <= req_size;
            off_q   <= req_addr[1:0];
            row_q   <= req_addr[ADDR_WIDTH-1:2];
            wdata_q <= req_wdata;
            err_q   <= req_error;
            mask_q  <= lane_mask(req_size, req_addr[1:0]);
        end
    end

    // Store data is right-justified, so narrow writes replicate into every lane they may hit.
    for (genvar k = 0; k < LANES; k++) begin : g_bank
        always_comb begin
            case (size_q)
                SIZE_BYTE: bank_din[k] = wdata_q[7:0];
                SIZE_HALF: bank_din[k] = (k % 2 == 1) ? wdata_q[15:8] : wdata_q[7:0];
                default:   bank_din[k] = wdata_q[8*k+7 -: 8];
            endcase
        end

        mem_byte_bank #(
            .ROW_BITS (ROW_BITS)
        ) u_bank (
            .clk  (clk),
            .en   (bank_en & mask_q[k]),
            .we   (write_q),
            .row  (row_q),
            .din  (bank_din[k]),
            .dout (bank_dout[k])
        );
    end

    always_comb begin
        rdata_live = '0;
        if (!err_q && !write_q) begin
            case (size_q)
                SIZE_BYTE: rdata_live[7:0]  = bank_dout[off_q];
                SIZE_HALF: rdata_live[15:0] = off_q[1] ? {bank_dout[3], bank_dout[2]}
                                                       : {bank_dout[1], bank_dout[0]};
                SIZE_WORD: rdata_live       = {bank_dout[3], bank_dout[2], bank_dout[1], bank_dout[0]};
                default:   rdata_live       = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_rdata <= '0;
            hold_error <= 1'b0;
        end else if (state == RESP) begin
            hold_rdata <= rdata_live;
            hold_error <= err_q;
        end
    end

    assign resp_rdata = (state == RESP) ? rdata_live : hold_rdata;
    assign resp_error = (state == RESP) ? err_q      : hold_error;

endmodule

// File: tb/tb_byte_mem_responder.sv
// tb/tb_byte_mem_responder.sv - scoreboard bench for byte_mem_responder
module tb_byte_mem_responder;

`ifdef MEM_WAIT_STATES_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int   cyc = 0;
    int   last_acc = -100;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    byte_mem_responder #(
        .WORD_SIZE   (32),
        .ADDR_WIDTH  (12),
        .WAIT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response is live on the negedge after the edge accept+LAT-1, captured at edge accept+LAT.
    always @(negedge clk) begin
        if (rst) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, (cyc >= last_acc + LAT)});
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_error", {31'd0, resp_error}, {31'd0, e.error});
                    chk("resp_latency", cyc - e.acc + 1, LAT);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input bit push, output int acc);
        bit ok;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        last_acc = cyc;
        if (push) sb.push_back('{er, ee, cyc});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
    endtask

    int a1, a2, a3, ax;

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        #9 rst = 1'b1;

        issue(1'b1, 2'b11, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, ax);
        issue(1'b0, 2'b11, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, ax);

        issue(1'b1, 2'b01, 32'h020, 32'h11, 32'h0, 1'b0, 1'b1, ax);
        issue(1'b1, 2'b01, 32'h021, 32'h22, 32'h0, 1'b0, 1'b1, ax);
        issue(1'b1, 2'b01, 32'h022, 32'h33, 32'h0, 1'b0, 1'b1, ax);
        issue(1'b1, 2'b01, 32'h023, 32'h44, 32'h0, 1'b0, 1'b1, ax);
        issue(1'b0, 2'b11, 32'h020, 32'h0, 32'h44332211, 1'b0, 1'b1, ax);
        issue(1'b0, 2'b10, 32'h022, 32'h0, 32'h00004433, 1'b0, 1'b1, ax);
        issue(1'b0, 2'b10, 32'h020, 32'h0, 32'h00002211, 1'b0, 1'b1, ax);
        issue(1'b0, 2'b01, 32'h023, 32'h0, 32'h00000044, 1'b0, 1'b1, ax);

        issue(1'b1, 2'b11, 32'h030, 32'h55667788, 32'h0, 1'b0, 1'b1, ax);
        issue(1'b1, 2'b10, 32'h031, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, ax);
        issue(1'b0, 2'b11, 32'h032, 32'h0, 32'h0, 1'b1, 1'b1, ax);
        issue(1'b0, 2'b00, 32'h040, 32'h0, 32'h0, 1'b1, 1'b1, ax);
        issue(1'b1, 2'b00, 32'h030, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, ax);
        issue(1'b0, 2'b11, 32'h030, 32'h0, 32'h55667788, 1'b0, 1'b1, ax);

        issue(1'b0, 2'b11, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b1, ax);
        issue(1'b1, 2'b11, 32'h1FFC, 32'h12345678, 32'h0, 1'b1, 1'b1, ax);
        issue(1'b1, 2'b11, 32'h0FFC, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, ax);
        issue(1'b0, 2'b11, 32'h0FFC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, ax);
        idle(2);
        drain();

        issue(1'b0, 2'b11, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, a1);
        issue(1'b0, 2'b11, 32'h020, 32'h0, 32'h44332211, 1'b0, 1'b1, a2);
        issue(1'b0, 2'b11, 32'h0FFC, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, a3);
        idle(1);
        chk("b2b_gap_1", a2 - a1, LAT + 1);
        chk("b2b_gap_2", a3 - a2, LAT + 1);
        drain();

        issue(1'b1, 2'b11, 32'h010, 32'h0BADF00D, 32'h0, 1'b0, 1'b0, ax);
        @(negedge clk);
        #2 rst = 1'b0;
        last_acc = -100;
        req_valid = 1'b0;
        #1;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        issue(1'b0, 2'b11, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, ax);
        idle(4);
        drain();
        chk("hold_rdata", resp_rdata, 32'hDEADBEEF);
        chk("hold_error", {31'd0, resp_error}, 32'd0);
        chk("hold_no_valid", {31'd0, resp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
